pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: width of PC, offsets, targets, counter.
REQ-002 Parameter RESET_PC, default 0: PC value loaded by reset.
REQ-003 Parameter ILEN, default 4: sequential increment in bytes; target alignment is ILEN bytes.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 stall  in  1  hold PC; blocks sequential advance and branch/jalr redirect.
REQ-007 br_taken  in  1  taken branch/jal redirect request.
REQ-008 isjalr  in  1  jalr redirect request.
REQ-009 offset  in  XLEN  signed redirect offset.
REQ-010 jalr_base  in  XLEN  jalr base register value.
REQ-011 trap_valid  in  1  trap redirect request.
REQ-012 trap_vector  in  XLEN  trap target address.
REQ-013 fetch_ready  in  1  fetch side accepts pc_now this cycle.
REQ-014 pc_now  out  XLEN  current PC (registered).
REQ-015 fetch_valid  out  1  pc_now is a valid fetch request.
REQ-016 pc_next  out  XLEN  value PC takes at next edge (combinational).
REQ-017 fault  out  1  misaligned-target fault pending (registered).
REQ-018 fault_addr  out  XLEN  offending target captured on fault.
REQ-019 fetch_count  out  XLEN  count of accepted fetches.

Function
REQ-020 States BOOT, RUN, FAULT; reset enters BOOT; BOOT -> RUN unconditionally after one cycle, no PC change.
REQ-021 fetch_valid = 1 only in RUN; 0 in BOOT and FAULT.
REQ-022 Fetch accepted in a cycle = fetch_valid & fetch_ready & ~stall.
REQ-023 Redirect target: base = isjalr ? jalr_base : pc_now; target = base + offset, mod 2^XLEN; jalr target bit 0 forced to 0.
REQ-024 isjalr and br_taken both high: treated as jalr.
REQ-025 Priority per cycle: trap_valid > (isjalr|br_taken, only if ~stall) > accepted fetch (pc_now + ILEN) > hold.
REQ-026 trap_valid acts in any state including BOOT and under stall; PC = trap_vector with low log2(ILEN) bits cleared; state -> RUN.
REQ-027 Branch/jalr redirect in RUN with ~stall: aligned target -> PC = target; misaligned target (low log2(ILEN) bits nonzero) -> PC holds, state -> FAULT, fault = 1, fault_addr = target.
REQ-028 Branch/jalr requests ignored in BOOT and FAULT.
REQ-029 Sequential advance only on accepted fetch without redirect; fetch_valid with ~fetch_ready holds PC and keeps request stable.
REQ-030 Sequential increment wraps: pc_now = 2^XLEN - ILEN advances to 0.
REQ-031 FAULT exits only via trap_valid; fault clears to 0 on that edge; fault_addr retains last value.
REQ-032 pc_next always equals the PC value loaded at the next edge per REQ-025..REQ-030.
REQ-033 fetch_count increments by 1 per accepted fetch, including the cycle a redirect overrides the advance; wraps at 2^XLEN.

Reset
REQ-034 Asserting rst immediately, independent of clk: pc_now = RESET_PC, state = BOOT, fetch_valid = 0, fault = 0, fault_addr = 0, fetch_count = 0.
REQ-035 Reset asserted mid-operation (any state, stall or pending redirect) discards all pending requests; no state update while rst low.
REQ-036 First edge after rst deasserts: BOOT -> RUN; fetch_valid = 1 following cycle with pc_now = RESET_PC.

Verification
REQ-037 Reset release, fetch_ready = 1, no redirects -> one cycle fetch_valid = 0, then pc_now = 0, 4, 8, 12; fetch_count = 1, 2, 3 after each accepted fetch.
REQ-038 pc_now = 0x100, br_taken = 1, offset = 0xFFFFFFF0, stall = 0 -> pc_now = 0xF0 next cycle; same with stall = 1 -> pc_now stays 0x100.
REQ-039 isjalr = 1, jalr_base = 0x2001, offset = 0x2 -> target 0x2002 misaligned -> fault = 1, fault_addr = 0x2002, fetch_valid = 0; then trap_valid = 1, trap_vector = 0x80 -> pc_now = 0x80, fault = 0, fetch_valid = 1.
REQ-040 pc_now = 0xFFFFFFFC, fetch accepted -> pc_now = 0x0; fetch_ready = 0 for 3 cycles -> pc_now and fetch_count unchanged.
REQ-041 Same cycle trap_valid = 1 (vector 0x203), br_taken = 1, stall = 1 -> pc_now = 0x200; rst pulsed low mid-cycle -> pc_now = RESET_PC asynchronously, fetch_valid = 0.

Source files
------------

// File: rtl/pc_gen_if.sv
// Request/response bundle between a core's control path and the PC generator.
// The master drives stall, redirect and trap requests; the slave returns PC and fetch status.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            br_taken;
  logic            isjalr;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] jalr_base;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            fetch_ready;
  logic [XLEN-1:0] pc_now;
  logic            fetch_valid;
  logic [XLEN-1:0] pc_next;
  logic            fault;
  logic [XLEN-1:0] fault_addr;
  logic [XLEN-1:0] fetch_count;

  modport master (
    output stall, br_taken, isjalr, offset, jalr_base,
    output trap_valid, trap_vector, fetch_ready,
    input  pc_now, fetch_valid, pc_next, fault, fault_addr, fetch_count
  );

  modport slave (
    input  stall, br_taken, isjalr, offset, jalr_base,
    input  trap_valid, trap_vector, fetch_ready,
    output pc_now, fetch_valid, pc_next, fault, fault_addr, fetch_count
  );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator: sequential fetch, branch/jalr redirect with alignment
// checking, trap redirect, misaligned-target fault state and an accepted-fetch counter.
module pc_gen #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     ILEN     = 4
) (
   input  logic     clk,
   input  logic     rst,
   pc_gen_if.slave  bus
);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   // ILEN is a power of two, so its low bits form the alignment mask.
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN - 1);
   localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            fault_q, fault_d;
   logic [XLEN-1:0] fault_addr_q, fault_addr_d;
   logic [XLEN-1:0] count_q;

   logic            in_run;
   logic            accept;
   logic            redirect;
   logic [XLEN-1:0] base;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] target;
   logic            misaligned;
   logic [XLEN-1:0] trap_target;

   assign in_run   = (state_q == ST_RUN);
   assign accept   = in_run & bus.fetch_ready & ~bus.stall;
   assign redirect = in_run & ~bus.stall & (bus.isjalr | bus.br_taken);

   // jalr wins over br_taken when both are raised.
   assign base        = bus.isjalr ? bus.jalr_base : pc_q;
   assign sum         = base + bus.offset;
   assign target      = bus.isjalr ? {sum[XLEN-1:1], 1'b0} : sum;
   assign misaligned  = |(target & ALIGN_MASK);
   assign trap_target = bus.trap_vector & ~ALIGN_MASK;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the if/else chain can leave it unassigned and infer a latch.
   always_comb begin
      pc_d         = pc_q;
      state_d      = state_q;
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;

      if (bus.trap_valid) begin
         pc_d    = trap_target;
         state_d = ST_RUN;
         fault_d = 1'b0;
      end else if (redirect) begin
         if (misaligned) begin
            state_d      = ST_FAULT;
            fault_d      = 1'b1;
            fault_addr_d = target;
         end else begin
            pc_d = target;
         end
      end else if (accept) begin
         pc_d = pc_q + STEP;
      end else if (state_q == ST_BOOT) begin
         state_d = ST_RUN;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         if (accept) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   assign bus.pc_now      = pc_q;
   assign bus.pc_next     = pc_d;
   assign bus.fetch_valid = in_run;
   assign bus.fault       = fault_q;
   assign bus.fault_addr  = fault_addr_q;
   assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen (XLEN=32, RESET_PC=0, ILEN=4) plus
// hand-written reset sequences.
module tb_pc_gen;

   logic clk;
   logic rst;

   pc_gen_if #(.XLEN(32)) bus ();

   pc_gen #(.XLEN(32), .RESET_PC(32'h0), .ILEN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        br;
      logic        jalr;
      logic [31:0] offset;
      logic [31:0] base;
      logic        trap;
      logic [31:0] vec;
      logic        fr;
      logic [31:0] e_pc;
      logic        e_fv;
      logic        e_fault;
      logic [31:0] e_addr;
      logic [31:0] e_cnt;
   } vec_t;

   localparam int NV = 20;
   vec_t tbl [NV];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic br, input logic jr,
                               input logic [31:0] off, input logic [31:0] bs,
                               input logic tr, input logic [31:0] tv, input logic fr,
                               input logic [31:0] e_pc, input logic e_fv, input logic e_fault,
                               input logic [31:0] e_addr, input logic [31:0] e_cnt);
      vec_t v;
      v.stall = st; v.br = br; v.jalr = jr; v.offset = off; v.base = bs;
      v.trap = tr; v.vec = tv; v.fr = fr;
      v.e_pc = e_pc; v.e_fv = e_fv; v.e_fault = e_fault; v.e_addr = e_addr; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic drive_idle();
      bus.stall       = 1'b0;
      bus.br_taken    = 1'b0;
      bus.isjalr      = 1'b0;
      bus.offset      = '0;
      bus.jalr_base   = '0;
      bus.trap_valid  = 1'b0;
      bus.trap_vector = '0;
      bus.fetch_ready = 1'b0;
   endtask

   task automatic check_outputs(input string tag, input logic [31:0] pc, input logic fv,
                                input logic flt, input logic [31:0] addr, input logic [31:0] cnt);
      check({tag, ".pc_now"},      bus.pc_now,             pc);
      check({tag, ".fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, fv});
      check({tag, ".fault"},       {31'd0, bus.fault},       {31'd0, flt});
      check({tag, ".fault_addr"},  bus.fault_addr,         addr);
      check({tag, ".fetch_count"}, bus.fetch_count,        cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //             st br jr offset        base          tr vec           fr  e_pc          fv flt e_addr        cnt
      tbl[0]  = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 32'h0,       32'd0); // BOOT -> RUN
      tbl[1]  = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h4,        1, 0, 32'h0,       32'd1);
      tbl[2]  = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h8,        1, 0, 32'h0,       32'd2);
      tbl[3]  = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'hC,        1, 0, 32'h0,       32'd3);
      tbl[4]  = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'hC,        1, 0, 32'h0,       32'd3); // not ready
      tbl[5]  = mk(1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'hC,        1, 0, 32'h0,       32'd3); // stalled
      tbl[6]  = mk(0, 0, 0, 32'h0,        32'h0,        1, 32'h100,      1, 32'h100,      1, 0, 32'h0,       32'd4); // trap + accept
      tbl[7]  = mk(1, 1, 0, 32'hFFFFFFF0, 32'h0,        0, 32'h0,        1, 32'h100,      1, 0, 32'h0,       32'd4); // stalled branch
      tbl[8]  = mk(0, 1, 0, 32'hFFFFFFF0, 32'h0,        0, 32'h0,        1, 32'hF0,       1, 0, 32'h0,       32'd5); // backward branch
      tbl[9]  = mk(0, 1, 1, 32'h8,        32'h1000,     0, 32'h0,        0, 32'h1008,     1, 0, 32'h0,       32'd5); // both -> jalr
      tbl[10] = mk(0, 0, 1, 32'h2,        32'h2001,     0, 32'h0,        0, 32'h1008,     0, 1, 32'h2002,    32'd5); // misaligned jalr
      tbl[11] = mk(0, 1, 0, 32'h40,       32'h0,        0, 32'h0,        1, 32'h1008,     0, 1, 32'h2002,    32'd5); // ignored in FAULT
      tbl[12] = mk(0, 0, 0, 32'h0,        32'h0,        1, 32'h80,       0, 32'h80,       1, 0, 32'h2002,    32'd5); // trap exits FAULT
      tbl[13] = mk(0, 1, 0, 32'h6,        32'h0,        0, 32'h0,        1, 32'h80,       0, 1, 32'h86,      32'd6); // misaligned branch
      tbl[14] = mk(0, 0, 0, 32'h0,        32'h0,        1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 1, 0, 32'h86,      32'd6);
      tbl[15] = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 32'h86,      32'd7); // wrap
      tbl[16] = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h86,      32'd7);
      tbl[17] = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h86,      32'd7);
      tbl[18] = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h86,      32'd7);
      tbl[19] = mk(1, 1, 0, 32'h40,       32'h0,        1, 32'h203,      1, 32'h200,      1, 0, 32'h86,      32'd7); // trap beats stalled branch

      rst = 1'b0;
      drive_idle();
      #12;
      check_outputs("reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'd0);

      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         bus.stall       = tbl[i].stall;
         bus.br_taken    = tbl[i].br;
         bus.isjalr      = tbl[i].jalr;
         bus.offset      = tbl[i].offset;
         bus.jalr_base   = tbl[i].base;
         bus.trap_valid  = tbl[i].trap;
         bus.trap_vector = tbl[i].vec;
         bus.fetch_ready = tbl[i].fr;
         #1;
         check($sformatf("v%0d.pc_next", i), bus.pc_next, tbl[i].e_pc);
         @(posedge clk);
         #1;
         check_outputs($sformatf("v%0d", i), tbl[i].e_pc, tbl[i].e_fv, tbl[i].e_fault,
                       tbl[i].e_addr, tbl[i].e_cnt);
         @(negedge clk);
      end

      // Async reset mid-cycle with a pending branch and fetch: clears without a clock edge.
      bus.br_taken    = 1'b1;
      bus.offset      = 32'h40;
      bus.fetch_ready = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check_outputs("async_rst", 32'h0, 1'b0, 1'b0, 32'h0, 32'd0);

      // Held in reset across an edge with requests pending: nothing moves.
      bus.trap_valid  = 1'b1;
      bus.trap_vector = 32'h300;
      @(posedge clk);
      #1;
      check_outputs("rst_held", 32'h0, 1'b0, 1'b0, 32'h0, 32'd0);

      // Release: one BOOT cycle with fetch_valid low, then fetching from RESET_PC.
      @(negedge clk);
      drive_idle();
      bus.fetch_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("boot.fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
      check("boot.pc_next", bus.pc_next, 32'h0);
      @(posedge clk);
      #1;
      check_outputs("post_boot", 32'h0, 1'b1, 1'b0, 32'h0, 32'd0);
      @(posedge clk);
      #1;
      check_outputs("first_fetch", 32'h4, 1'b1, 1'b0, 32'h0, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
